// File: rtl/scmp_bus_ctl_pkg.sv
// Shared types and default timing for the SC/MP external bus cycle controller.
package scmp_bus_pak;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ADS  = 3'd2,
    ST_STB  = 3'd3,
    ST_DONE = 3'd4,
    ST_PARK = 3'd5
  } BUS_STATE_t;

  typedef struct packed {
    logic h;
    logic d;
    logic i;
    logic r;
  } BUS_FLAGS_t;

  localparam int T_ADS_DEF = 1;
  localparam int T_STB_DEF = 2;
  localparam int TO_W_DEF  = 8;

  // Status byte placed on the data bus while ADS is low.
  function automatic logic [7:0] ads_drive(input BUS_FLAGS_t f, input logic [3:0] addr_hi);
    return {f.r, f.i, f.d, f.h, addr_hi};
  endfunction

endpackage

// File: rtl/scmp_bus_ctl_arb.sv
// BREQ/ENIN/ENOUT daisy-chain handshake; grant is combinational from the latched request.
module scmp_bus_arb (
  input  logic clk,
  input  logic rst,
  input  logic breq_set,
  input  logic breq_clr,
  input  logic enin,
  output logic breq_out,
  output logic enout,
  output logic grant
);

  // Request latch and registered pass-through of the enable chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      breq_out <= 1'b0;
      enout    <= 1'b0;
    end else begin
      enout <= enin & ~breq_out;
      if (breq_set) begin
        breq_out <= 1'b1;
      end else if (breq_clr) begin
        breq_out <= 1'b0;
      end else begin
        breq_out <= breq_out;
      end
    end
  end

  assign grant = enin & breq_out;

endmodule

// File: rtl/scmp_bus_ctl.sv
// Bus cycle controller: arbitration, ADS phase, RD/WR strobe with NHOLD wait states.
// Optional bus parking between cycles is enabled by defining SCMP_BUS_PARK_EN.
module scmp_bus_ctl
  import scmp_bus_pak::*;
#(
  parameter int T_ADS = T_ADS_DEF,
  parameter int T_STB = T_STB_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [3:0]  req_flags,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_done,
  output logic        req_err,
  output logic [7:0]  rsp_rdata,
  output logic        breq_out,
  input  logic        enin,
  output logic        enout,
  output logic        bus_ads_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  input  logic        bus_hold_n,
  output logic [11:0] bus_addr,
  output logic [7:0]  bus_db_out,
  output logic        bus_db_oe,
  input  logic [7:0]  bus_db_in
);

  localparam int PH_W = $clog2(T_ADS + T_STB + 1);
  localparam logic [PH_W-1:0] PH_MAX   = {PH_W{1'b1}};
  localparam logic [PH_W-1:0] ADS_LAST = PH_W'(T_ADS - 1);
  localparam logic [PH_W-1:0] STB_LAST = PH_W'(T_STB - 1);
  localparam logic [TO_W-1:0] HOLD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  BUS_STATE_t      state_r;
  logic [PH_W-1:0] phase_r;
  logic [TO_W-1:0] hold_r;
  logic            grant_s;
  logic            req_ok_s;
  logic            ads_go_s;
  logic            err_go_s;
  logic            stb_samp_s;
  logic            stb_end_s;
  logic            breq_set_s;
  logic            breq_clr_s;

  scmp_bus_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .breq_set (breq_set_s),
    .breq_clr (breq_clr_s),
    .enin     (enin),
    .breq_out (breq_out),
    .enout    (enout),
    .grant    (grant_s)
  );

  assign req_ok_s   = req_valid & (req_rd ^ req_wr);
  assign stb_samp_s = (state_r == ST_STB) && (phase_r >= STB_LAST);
  assign stb_end_s  = stb_samp_s && (bus_hold_n || (hold_r == HOLD_LAST));

  // Transition qualifiers shared by the FSM and the arbiter request latch.
  always_comb begin
    ads_go_s   = 1'b0;
    err_go_s   = 1'b0;
    breq_set_s = 1'b0;
    breq_clr_s = 1'b0;
    if (state_r == ST_ARB) begin
      ads_go_s = grant_s;
    end else if (state_r == ST_IDLE) begin
      err_go_s   = req_valid & ~req_ok_s;
      breq_set_s = req_ok_s;
    end else begin
      ads_go_s = 1'b0;
    end
`ifdef SCMP_BUS_PARK_EN
    if (state_r == ST_PARK) begin
      ads_go_s   = enin & req_ok_s;
      err_go_s   = enin & req_valid & ~req_ok_s;
      breq_clr_s = ~enin;
    end else begin
      breq_clr_s = 1'b0;
    end
`else
    breq_clr_s = stb_end_s;
`endif
  end

  // Cycle FSM with phase/hold counters and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      phase_r    <= {PH_W{1'b0}};
      hold_r     <= {TO_W{1'b0}};
      req_done   <= 1'b0;
      req_err    <= 1'b0;
      rsp_rdata  <= 8'h00;
      bus_ads_n  <= 1'b1;
      bus_rd_n   <= 1'b1;
      bus_wr_n   <= 1'b1;
      bus_addr   <= 12'h000;
      bus_db_out <= 8'h00;
      bus_db_oe  <= 1'b0;
    end else begin
      req_done <= 1'b0;
      req_err  <= 1'b0;
      phase_r  <= (phase_r == PH_MAX) ? phase_r : phase_r + PH_W'(1);
      if (ads_go_s) begin
        state_r    <= ST_ADS;
        phase_r    <= {PH_W{1'b0}};
        bus_ads_n  <= 1'b0;
        bus_addr   <= req_addr[11:0];
        bus_db_out <= ads_drive(BUS_FLAGS_t'(req_flags), req_addr[15:12]);
        bus_db_oe  <= 1'b1;
      end else if (err_go_s) begin
        state_r  <= ST_DONE;
        phase_r  <= {PH_W{1'b0}};
        req_done <= 1'b1;
        req_err  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (req_valid) begin
              state_r <= ST_ARB;
              phase_r <= {PH_W{1'b0}};
            end
          end
          ST_ARB: begin
            state_r <= ST_ARB;
          end
          ST_ADS: begin
            if (phase_r == ADS_LAST) begin
              state_r   <= ST_STB;
              phase_r   <= {PH_W{1'b0}};
              hold_r    <= {TO_W{1'b0}};
              bus_ads_n <= 1'b1;
              bus_rd_n  <= ~req_rd;
              bus_wr_n  <= ~req_wr;
              bus_db_oe <= req_wr;
              if (req_wr) begin
                bus_db_out <= req_wdata;
              end
            end
          end
          ST_STB: begin
            if (stb_end_s) begin
              state_r   <= ST_DONE;
              phase_r   <= {PH_W{1'b0}};
              req_done  <= 1'b1;
              bus_rd_n  <= 1'b1;
              bus_wr_n  <= 1'b1;
              bus_db_oe <= 1'b0;
              if (!bus_hold_n) begin
                req_err   <= 1'b1;
                rsp_rdata <= 8'hFF;
              end else if (req_rd) begin
                rsp_rdata <= bus_db_in;
              end
            end else if (stb_samp_s) begin
              hold_r <= hold_r + TO_W'(1);
            end
          end
          ST_DONE: begin
            phase_r <= {PH_W{1'b0}};
`ifdef SCMP_BUS_PARK_EN
            state_r <= breq_out ? ST_PARK : ST_IDLE;
`else
            state_r <= ST_IDLE;
`endif
          end
          ST_PARK: begin
            if (!enin) begin
              state_r <= ST_IDLE;
              phase_r <= {PH_W{1'b0}};
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Directed bench for scmp_bus_ctl; the park scenario runs when SCMP_BUS_PARK_EN is defined.
module tb_scmp_bus_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_rd, req_wr;
  logic [3:0]  req_flags;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_done, req_err;
  logic [7:0]  rsp_rdata;
  logic        breq_out, enin, enout;
  logic        bus_ads_n, bus_rd_n, bus_wr_n, bus_hold_n;
  logic [11:0] bus_addr;
  logic [7:0]  bus_db_out, bus_db_in;
  logic        bus_db_oe;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  logic seen;

  scmp_bus_ctl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
    .req_flags(req_flags), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
    .breq_out(breq_out), .enin(enin), .enout(enout),
    .bus_ads_n(bus_ads_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_hold_n(bus_hold_n),
    .bus_addr(bus_addr), .bus_db_out(bus_db_out), .bus_db_oe(bus_db_oe), .bus_db_in(bus_db_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [3:0] fl,
                       input logic [15:0] a, input logic [7:0] wd);
    req_valid = 1'b1; req_rd = rd; req_wr = wr;
    req_flags = fl; req_addr = a; req_wdata = wd;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget && !req_done) begin
      step();
      n++;
    end
  endtask

  task automatic idle_bus();
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    enin = 1'b0;
    step(); step();
    enin = 1'b1;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; enin = 1'b1; bus_hold_n = 1'b1; bus_db_in = 8'h00;
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    req_flags = 4'h0; req_addr = 16'h0000; req_wdata = 8'h00;
    step(); step();
    chk("rst_strobes", {bus_ads_n, bus_rd_n, bus_wr_n}, 3'b111);
    chk("rst_ctl", {breq_out, enout, bus_db_oe, req_done, req_err}, 5'b00000);
    chk("rst_rdata", rsp_rdata, 8'h00);
    rst = 1'b0;
    step();

    // Read 16'h1A35 with R flag
    bus_db_in = 8'h5C;
    issue(1'b1, 1'b0, 4'b0001, 16'h1A35, 8'h00);
    step();
    chk("rd_c1_breq", breq_out, 1'b1);
    chk("rd_c1_ads", bus_ads_n, 1'b1);
    step();
    chk("rd_c2_ads", bus_ads_n, 1'b0);
    chk("rd_c2_addr", bus_addr, 12'hA35);
    chk("rd_c2_db", {bus_db_oe, bus_db_out}, {1'b1, 8'h81});
    step();
    chk("rd_c3_rd", {bus_ads_n, bus_rd_n, bus_db_oe, enout}, 4'b1000);
    step();
    chk("rd_c4_rd", bus_rd_n, 1'b0);
    step();
    chk("rd_c5_done", {req_done, req_err, bus_rd_n}, 3'b101);
    chk("rd_c5_data", rsp_rdata, 8'h5C);
    req_valid = 1'b0;
    step();
    chk("rd_c6_nodone", req_done, 1'b0);

    // Write 16'h0F00 / 8'hA7
    idle_bus();
    issue(1'b0, 1'b1, 4'b0000, 16'h0F00, 8'hA7);
    step(); step();
    chk("wr_c2_ads", {bus_ads_n, bus_addr, bus_db_out}, {1'b0, 12'hF00, 8'h00});
    step();
    chk("wr_c3", {bus_wr_n, bus_rd_n, bus_db_oe, bus_db_out}, {3'b011, 8'hA7});
    step();
    chk("wr_c4", {bus_wr_n, bus_rd_n}, 2'b01);
    step();
    chk("wr_c5_done", {req_done, req_err, bus_wr_n, bus_rd_n}, 4'b1011);
    req_valid = 1'b0;

    // Arbitration wait with enin low
    idle_bus();
    chk("idle_enout", enout, 1'b1);
    enin = 1'b0;
    issue(1'b1, 1'b0, 4'b0000, 16'h0123, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus_ads_n) seen = 1'b1;
    end
    chk("arb_wait", {breq_out, enout, seen}, 3'b100);
    enin = 1'b1;
    step();
    chk("arb_grant_ads", bus_ads_n, 1'b0);
    wait_done(10, cyc);
    chk("arb_done_lat", cyc, 3);
    req_valid = 1'b0;

    // Hold for 3 cycles from the last strobe cycle
    idle_bus();
    bus_db_in = 8'h3C;
    issue(1'b1, 1'b0, 4'b0000, 16'h0200, 8'h00);
    for (int i = 0; i < 4; i++) step();
    bus_hold_n = 1'b0;
    step();
    chk("hold_c5", {bus_rd_n, req_done}, 2'b00);
    step(); step();
    chk("hold_c7", {bus_rd_n, req_done}, 2'b00);
    bus_hold_n = 1'b1;
    step();
    chk("hold_c8_done", {req_done, req_err, bus_rd_n}, 3'b101);
    chk("hold_c8_data", rsp_rdata, 8'h3C);
    req_valid = 1'b0;

    // Stuck hold -> timeout
    idle_bus();
    bus_hold_n = 1'b0;
    bus_db_in = 8'h11;
    issue(1'b1, 1'b0, 4'b0000, 16'h0300, 8'h00);
    wait_done(400, cyc);
    chk("to_latency", cyc, 259);
    chk("to_err", {req_done, req_err, bus_rd_n}, 3'b111);
    chk("to_data", rsp_rdata, 8'hFF);
    req_valid = 1'b0;
    bus_hold_n = 1'b1;

    // Reset mid-strobe
    idle_bus();
    issue(1'b1, 1'b0, 4'b0000, 16'h0400, 8'h00);
    step(); step(); step();
    chk("rs_pre", bus_rd_n, 1'b0);
    rst = 1'b1;
    step();
    chk("rs_after", {bus_ads_n, bus_rd_n, bus_wr_n, breq_out, req_done}, 5'b11100);
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (req_done) seen = 1'b1;
    end
    chk("rs_nodone", seen, 1'b0);

    // Both rd and wr set -> rejected
    issue(1'b1, 1'b1, 4'b0000, 16'h0500, 8'h00);
    step();
    chk("bad_done", {req_done, req_err}, 2'b11);
    chk("bad_pins", {bus_ads_n, bus_rd_n, bus_wr_n, breq_out}, 4'b1110);
    req_valid = 1'b0;
    step();

`ifdef SCMP_BUS_PARK_EN
    // Back-to-back reads with bus parking
    idle_bus();
    bus_db_in = 8'h66;
    issue(1'b1, 1'b0, 4'b0000, 16'h0600, 8'h00);
    wait_done(10, cyc);
    chk("park_first_lat", cyc, 5);
    bus_db_in = 8'h77;
    step();
    chk("park_breq", breq_out, 1'b1);
    wait_done(10, cyc);
    chk("park_second_lat", cyc, 4);
    chk("park_second", {rsp_rdata, breq_out}, {8'h77, 1'b1});
    idle_bus();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
